// File: rtl/mux4_sel_pkg.sv
// Shared types, constants and helpers for the 4:1 mux round-robin select controller.
package mux4_sel_pkg;

    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    localparam logic [IDX_W-1:0] PTR_RST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // One-hot encode a mux input index.
    function automatic logic [3:0] onehot4(input logic [IDX_W-1:0] idx);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: finds the first set request bit
// searching upward from (ptr+1) mod 4 with wrap-around.
module rr_pick4
    import mux4_sel_pkg::*;
(
    input  logic [3:0]       req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand_s;

    // Scan from the farthest candidate down so the nearest set bit after ptr wins.
    always_comb begin
        idx    = 2'd0;
        valid  = 1'b0;
        cand_s = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand_s = ptr + 2'd1 + k[1:0];
            if (req[cand_s]) begin
                idx   = cand_s;
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sel.sv
// Round-robin select controller for a 4:1 data mux.
// Optional feature: define MUX4_SEL_TIMEOUT_EN to force a release after
// TIMEOUT cycles of ownership (pulsing `timeout`); otherwise `timeout` stays 0.
module mux4_rr_sel
    import mux4_sel_pkg::*;
#(
    parameter int MIN_HOLD = 2,
    parameter int TIMEOUT  = 16
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       timeout
);

    if (MIN_HOLD < 1 || MIN_HOLD > 255 || TIMEOUT < MIN_HOLD || TIMEOUT > 255) begin : g_cfg_check
        $error("mux4_rr_sel: MIN_HOLD/TIMEOUT out of range");
    end

    localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_HOLD - 1);

    state_t           state_r, state_nxt_s;
    logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
    logic             pend_r, pend_nxt_s;
    logic [3:0]       gnt_r, gnt_nxt_s;
    logic [IDX_W-1:0] sel_r, sel_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             timeout_r, timeout_nxt_s;

    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_valid_s;
    logic             min_met_s;
    logic             rel_req_s;
    logic             to_hit_s;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // A release is wanted on done, on the owner dropping its request, or on an
    // earlier such event that arrived before the minimum dwell was met.
    assign min_met_s = (hold_cnt_r >= MIN_M1);
    assign rel_req_s = done | ~req[ptr_r] | pend_r;

`ifdef MUX4_SEL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
    assign to_hit_s = (hold_cnt_r >= TO_M1);
`else
    assign to_hit_s = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/OWN/GAP arbiter.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        hold_cnt_nxt_s = hold_cnt_r;
        pend_nxt_s     = pend_r;
        gnt_nxt_s      = gnt_r;
        sel_nxt_s      = sel_r;
        busy_nxt_s     = busy_r;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            IDLE, GAP: begin
                if (pick_valid_s) begin
                    state_nxt_s    = OWN;
                    gnt_nxt_s      = onehot4(pick_idx_s);
                    sel_nxt_s      = pick_idx_s;
                    ptr_nxt_s      = pick_idx_s;
                    hold_cnt_nxt_s = 8'd0;
                    pend_nxt_s     = 1'b0;
                    busy_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    gnt_nxt_s   = 4'b0000;
                    busy_nxt_s  = 1'b0;
                end
            end
            OWN: begin
                hold_cnt_nxt_s = sat_inc(hold_cnt_r);
                if (min_met_s && rel_req_s) begin
                    state_nxt_s = GAP;
                    gnt_nxt_s   = 4'b0000;
                    busy_nxt_s  = 1'b0;
                    pend_nxt_s  = 1'b0;
                end else if (to_hit_s) begin
                    state_nxt_s   = GAP;
                    gnt_nxt_s     = 4'b0000;
                    busy_nxt_s    = 1'b0;
                    pend_nxt_s    = 1'b0;
                    timeout_nxt_s = 1'b1;
                end else begin
                    pend_nxt_s = pend_r | done | ~req[ptr_r];
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = 4'b0000;
                busy_nxt_s  = 1'b0;
                pend_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset lands immediately in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= PTR_RST;
            hold_cnt_r <= 8'd0;
            pend_r     <= 1'b0;
            gnt_r      <= 4'b0000;
            sel_r      <= 2'd0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            pend_r     <= pend_nxt_s;
            gnt_r      <= gnt_nxt_s;
            sel_r      <= sel_nxt_s;
            busy_r     <= busy_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    assign gnt     = gnt_r;
    assign s0      = sel_r[0];
    assign s1      = sel_r[1];
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Directed self-checking bench for mux4_rr_sel (MIN_HOLD=2, TIMEOUT=16).
module tb_mux4_rr_sel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       s0, s1, busy, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mux4_rr_sel #(.MIN_HOLD(2), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .s0      (s0),
        .s1      (s1),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] alt_gnt [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    logic [1:0] alt_sel [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [3:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    int own_cycles;
    int to_seen;
    logic to_at_drop;

    initial begin
        // Reset state
        tick();
        check_eq("rst_gnt", gnt, 4'b0000);
        check_eq("rst_sel", {s1, s0}, 2'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);
        rst = 1'b0;
        tick();
        check_eq("idle_gnt", gnt, 4'b0000);

        // Alternating requesters, done in the third OWN cycle
        req = 4'b0101;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("alt_gnt%0d", i), gnt, alt_gnt[i]);
            check_eq($sformatf("alt_sel%0d", i), {s1, s0}, alt_sel[i]);
            check_eq($sformatf("alt_busy%0d", i), busy, 1'b1);
            tick();
            tick();
            check_eq($sformatf("alt_hold%0d", i), gnt, alt_gnt[i]);
            done = 1'b1;
            tick();
            done = 1'b0;
            check_eq($sformatf("alt_gap%0d", i), gnt, 4'b0000);
            check_eq($sformatf("alt_gapsel%0d", i), {s1, s0}, alt_sel[i]);
            if (i == 3) begin
                req = 4'b0000;
            end
            tick();
        end
        check_eq("alt_idle_gnt", gnt, 4'b0000);
        check_eq("alt_idle_sel", {s1, s0}, 2'd2);
        check_eq("alt_idle_busy", busy, 1'b0);

        // Early done: done in first OWN cycle, grant still lasts 2 cycles
        req = 4'b0010;
        tick();
        check_eq("early_gnt", gnt, 4'b0010);
        check_eq("early_sel", {s1, s0}, 2'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_eq("early_hold", gnt, 4'b0010);
        tick();
        check_eq("early_rel", gnt, 4'b0000);
        tick();
        check_eq("sole_regrant", gnt, 4'b0010);

        // Owner drops its request without done
        req = 4'b0000;
        tick();
        check_eq("drop_hold", gnt, 4'b0010);
        tick();
        check_eq("drop_rel", gnt, 4'b0000);
        tick();
        check_eq("drop_idle_gnt", gnt, 4'b0000);
        check_eq("drop_idle_busy", busy, 1'b0);
        tick();
        check_eq("drop_idle2", gnt, 4'b0000);

        // Reset asserted between edges in the middle of a grant
        req = 4'b0100;
        tick();
        check_eq("pre_rst_gnt", gnt, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_gnt", gnt, 4'b0000);
        check_eq("arst_sel", {s1, s0}, 2'd0);
        check_eq("arst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        req = 4'b1000;
        tick();
        check_eq("post_rst_gnt", gnt, 4'b1000);
        check_eq("post_rst_sel", {s1, s0}, 2'd3);
        req = 4'b0000;
        tick();
        tick();
        check_eq("post_rst_rel", gnt, 4'b0000);
        tick();

        // Full contention with done held high
        req  = 4'b1111;
        done = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("rr_gnt%0d_a", i), gnt, rr_gnt[i]);
            tick();
            check_eq($sformatf("rr_gnt%0d_b", i), gnt, rr_gnt[i]);
            tick();
            check_eq($sformatf("rr_gap%0d", i), gnt, 4'b0000);
            check_eq($sformatf("rr_gapbusy%0d", i), busy, 1'b0);
            tick();
        end
        req  = 4'b0000;
        done = 1'b0;
        tick();
        tick();
        tick();
        check_eq("rr_idle", gnt, 4'b0000);

        // Owner holds with no done: timeout behaviour depends on build
        req = 4'b0100;
        tick();
        check_eq("to_gnt", gnt, 4'b0100);
        own_cycles = 1;
        to_seen    = 0;
        to_at_drop = 1'b0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (timeout) begin
                to_seen++;
            end
            if (gnt == 4'b0100) begin
                own_cycles++;
            end else begin
                to_at_drop = timeout;
                break;
            end
        end
`ifdef MUX4_SEL_TIMEOUT_EN
        check_eq("to_own_cycles", own_cycles, 16);
        check_eq("to_pulse_at_drop", to_at_drop, 1'b1);
        tick();
        check_eq("to_pulse_cleared", timeout, 1'b0);
        check_eq("to_regrant", gnt, 4'b0100);
        check_eq("to_pulse_count", to_seen, 1);
`else
        check_eq("noto_own_cycles", own_cycles, 121);
        check_eq("noto_timeout", to_seen, 0);
`endif
        req = 4'b0000;
        tick();
        tick();
        tick();
        check_eq("end_gnt", gnt, 4'b0000);
        check_eq("end_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
